// File: rtl/voice_alloc_avm_master.sv
`default_nettype none
// ============================================================================
// voice_alloc_avm_master: note-event FIFO, voice allocator, Avalon-MM writer
// Revision 1.0
// ============================================================================
module voice_alloc_avm_master #(
    parameter int NUM_VOICES = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int KEY_BASE   = 32,
    parameter int FREQ_BASE  = 40,
    parameter int AMP_BASE   = 48
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  ev_valid,
    output logic                  ev_ready,
    input  logic                  ev_on,
    input  logic [6:0]            ev_note,
    input  logic [6:0]            ev_vel,
    output logic [5:0]            avm_addr,
    output logic                  avm_write,
    output logic                  avm_cs,
    output logic [3:0]            avm_byte_en,
    output logic [31:0]           avm_writedata,
    input  logic                  avm_waitrequest,
    output logic [NUM_VOICES-1:0] voice_active,
    output logic                  busy,
    output logic                  drop
);
    localparam int VIDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        DECODE    = 3'd1,
        WR_KEYOFF = 3'd2,
        WR_FREQ   = 3'd3,
        WR_AMP    = 3'd4,
        WR_KEYON  = 3'd5
    } state_t;

    state_t state, next_state;

    logic [14:0]      fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count;
    logic             push, pop;

    logic             cur_on;
    logic [6:0]       cur_note, cur_vel;

    logic [NUM_VOICES-1:0] active;
    logic [6:0]            note_tab [NUM_VOICES];
    logic [VIDX_W-1:0]     steal_ptr, vsel, dec_voice;
    logic                  dec_set, dec_clear, dec_steal;
    logic                  match_found, free_found;
    logic [VIDX_W-1:0]     match_idx, free_idx;

    // Full stays not-ready even when a pop coincides, so ready never depends on pop.
    assign ev_ready     = (count != CNT_W'(FIFO_DEPTH));
    assign push         = ev_valid && ev_ready;
    assign avm_cs       = avm_write;
    assign avm_byte_en  = 4'b1111;
    assign voice_active = active;
    assign busy         = (state != IDLE) || (count != '0);

    always_ff @(posedge clk) begin
        if (push)
            fifo_mem[wr_ptr] <= {ev_on, ev_note, ev_vel};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            cur_on   <= 1'b0;
            cur_note <= '0;
            cur_vel  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop) begin
                rd_ptr                      <= rd_ptr + PTR_W'(1);
                {cur_on, cur_note, cur_vel} <= fifo_mem[rd_ptr];
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: ;
            endcase
        end
    end

    // Descending scan so the lowest matching / free index ends up selected.
    always_comb begin
        match_found = 1'b0;
        match_idx   = '0;
        free_found  = 1'b0;
        free_idx    = '0;
        for (int i = NUM_VOICES - 1; i >= 0; i--) begin
            if (active[i] && (note_tab[i] == cur_note)) begin
                match_found = 1'b1;
                match_idx   = VIDX_W'(i);
            end
            if (!active[i]) begin
                free_found = 1'b1;
                free_idx   = VIDX_W'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state <= IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state    = state;
        pop           = 1'b0;
        drop          = 1'b0;
        avm_write     = 1'b0;
        avm_addr      = '0;
        avm_writedata = '0;
        dec_voice     = vsel;
        dec_set       = 1'b0;
        dec_clear     = 1'b0;
        dec_steal     = 1'b0;
        case (state)
            IDLE: begin
                if (count != '0) begin
                    pop        = 1'b1;
                    next_state = DECODE;
                end
            end
            DECODE: begin
                if (cur_on) begin
                    if (match_found) begin
                        dec_voice  = match_idx;
                        next_state = WR_KEYOFF;
                    end else if (free_found) begin
                        dec_voice  = free_idx;
                        dec_set    = 1'b1;
                        next_state = WR_FREQ;
                    end else begin
                        dec_voice  = steal_ptr;
                        dec_set    = 1'b1;
                        dec_steal  = 1'b1;
                        next_state = WR_KEYOFF;
                    end
                end else if (match_found) begin
                    dec_voice  = match_idx;
                    dec_clear  = 1'b1;
                    next_state = WR_KEYOFF;
                end else begin
                    drop       = 1'b1;
                    next_state = IDLE;
                end
            end
            WR_KEYOFF: begin
                avm_write = 1'b1;
                avm_addr  = 6'(KEY_BASE) + 6'(vsel);
                if (!avm_waitrequest)
                    next_state = cur_on ? WR_FREQ : IDLE;
            end
            WR_FREQ: begin
                avm_write     = 1'b1;
                avm_addr      = 6'(FREQ_BASE) + 6'(vsel);
                avm_writedata = {25'b0, cur_note};
                if (!avm_waitrequest)
                    next_state = WR_AMP;
            end
            WR_AMP: begin
                avm_write     = 1'b1;
                avm_addr      = 6'(AMP_BASE) + 6'(vsel);
                avm_writedata = {16'b0, cur_vel, 9'b0};
                if (!avm_waitrequest)
                    next_state = WR_KEYON;
            end
            WR_KEYON: begin
                avm_write     = 1'b1;
                avm_addr      = 6'(KEY_BASE) + 6'(vsel);
                avm_writedata = 32'd1;
                if (!avm_waitrequest)
                    next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            active    <= '0;
            steal_ptr <= '0;
            vsel      <= '0;
            for (int i = 0; i < NUM_VOICES; i++)
                note_tab[i] <= '0;
        end else begin
            vsel <= dec_voice;
            if (dec_set) begin
                active[dec_voice]   <= 1'b1;
                note_tab[dec_voice] <= cur_note;
            end
            if (dec_clear)
                active[dec_voice] <= 1'b0;
            if (dec_steal)
                steal_ptr <= (steal_ptr == VIDX_W'(NUM_VOICES - 1)) ? '0 : steal_ptr + VIDX_W'(1);
        end
    end
endmodule
`default_nettype wire

// File: doc/voice_alloc_avm_master.md
Name: voice_alloc_avm_master

Overview:
- Avalon-MM write-only master that drives the synth control register file from note events.
- Accepts note-on/note-off events from the upstream note/MIDI parser into a small FIFO.
- Allocates one of up to four voices per note-on, then issues the KEY/FREQ/AMP register writes the synth core consumes.
- Sits between the note parser and the control register slave, in parallel with the CPU master, behind the same interconnect.

Parameters:
- NUM_VOICES, 4, number of voices managed; legal values 1..4.
- FIFO_DEPTH, 4, event FIFO entries; power of 2, at least 2.
- KEY_BASE, 32, word address of KEY0; KEYv is at KEY_BASE+v.
- FREQ_BASE, 40, word address of FREQ0.
- AMP_BASE, 48, word address of AMP1_0.

Ports:
- CLK  in  1  system clock.
- RESET_N  in  1  asynchronous, active-low reset.
- EV_VALID  in  1  event offered.
- EV_READY  out  1  FIFO can accept; equals not-full.
- EV_ON  in  1  1 = note-on, 0 = note-off.
- EV_NOTE  in  7  MIDI note number.
- EV_VEL  in  7  velocity; ignored for note-off.
- AVM_ADDR  out  6  word address.
- AVM_WRITE  out  1  write request.
- AVM_CS  out  1  chip select; equals AVM_WRITE.
- AVM_BYTE_EN  out  4  always 4'b1111.
- AVM_WRITEDATA  out  32  write data.
- AVM_WAITREQUEST  in  1  slave stall; tie 0 for a zero-wait slave.
- VOICE_ACTIVE  out  NUM_VOICES  per-voice allocated flag.
- BUSY  out  1  FSM not in IDLE, or FIFO not empty.
- DROP  out  1  one-cycle pulse: note-off matched no voice.

Behaviour:
- Clocking and reset: one clock, CLK. RESET_N is asynchronous and active-low.
- Reset values:
  - All outputs are 0, except EV_READY = 1 and AVM_BYTE_EN = 4'b1111.
  - FIFO is empty; voice table is cleared; steal pointer = 0; FSM is in IDLE.
  - Reset asserted mid-transfer drops AVM_WRITE at once and discards the in-flight and queued events.
- FIFO:
  - A push occurs when EV_VALID && EV_READY; the entry stores {EV_ON, EV_NOTE, EV_VEL}.
  - When full, EV_READY = 0 even if a pop happens in the same cycle.
  - A pop happens only in IDLE with the FIFO not empty.
  - Pointers wrap modulo FIFO_DEPTH; a separate count distinguishes full from empty.
- Voice table: for each voice, an active bit and a 7-bit note.
- FSM states: IDLE, DECODE, WR_KEYOFF, WR_FREQ, WR_AMP, WR_KEYON.
- IDLE: when the FIFO is not empty, pop into the event register and go to DECODE.
- DECODE (exactly one cycle): selects voice v, updates the voice table in this cycle, and picks the next state.
  - Note-on, note already active on voice v (lowest index wins): retrigger. Path is WR_KEYOFF, WR_FREQ, WR_AMP, WR_KEYON.
  - Note-on, a free voice exists: v = lowest free index; set active and note. Path is WR_FREQ, WR_AMP, WR_KEYON.
  - Note-on, all voices active: steal. v = steal pointer; overwrite its note; steal pointer increments modulo NUM_VOICES. Path is WR_KEYOFF, WR_FREQ, WR_AMP, WR_KEYON.
  - Note-off matching active voice v (lowest index): clear active. Path is WR_KEYOFF then IDLE.
  - Note-off with no match: pulse DROP, return to IDLE, issue no write.
- Write states (all follow the same rule):
  - Drive AVM_WRITE = 1 with address and data.
  - Hold all three stable while AVM_WAITREQUEST = 1.
  - Advance on the first cycle where AVM_WRITE && !AVM_WAITREQUEST.
  - AVM_WRITE is deasserted for at least one cycle (IDLE/DECODE) between events. It stays asserted back-to-back inside one event's sequence.
- Write contents:
  - WR_KEYOFF: addr KEY_BASE+v, data 0.
  - WR_FREQ: addr FREQ_BASE+v, data {25'b0, note}.
  - WR_AMP: addr AMP_BASE+v, data {16'b0, vel, 9'b0}.
  - WR_KEYON: addr KEY_BASE+v, data 1.
- Latency: with zero wait, a new-voice note-on takes 1 (IDLE) + 1 (DECODE) + 3 write cycles. The first write is in cycle 3 after the FIFO becomes non-empty.
- AVM_WRITEDATA and AVM_ADDR are don't-care while AVM_WRITE = 0; drive them to 0.

Test Plan:
- Zero-wait note-on (on=1, note=60, vel=100) from reset:
  - Writes are (40, 60), (48, 0xC800), (32, 1) on consecutive cycles.
  - VOICE_ACTIVE = 4'b0001.
- Four note-ons 60, 62, 64, 65, then note-on 67:
  - Voice 0 is stolen with writes (32, 0), (40, 67), (48, ...), (33 is not touched), (32, 1).
  - The steal pointer becomes 1, and the next steal hits voice 1.
- Note-on 60 then note-off 60:
  - Note-off produces a single write (32, 0); VOICE_ACTIVE returns to 0.
  - Note-off 61 afterwards gives a DROP pulse and no AVM_WRITE.
- AVM_WAITREQUEST held high for 5 cycles on WR_AMP:
  - Address and data stay stable for 6 cycles; WR_KEYON follows the next cycle.
- Push 6 events while the master is stalled, with FIFO_DEPTH = 4:
  - EV_READY goes low after 4 accepted events.
  - Pushes resume after the pops, and all accepted events are serviced in order.
- Assert RESET_N low mid-WR_FREQ:
  - AVM_WRITE is 0 in the same cycle; after release, VOICE_ACTIVE = 0 and FIFO is empty.
